digitizer_core: RTL and testbench
=================================

# digitizer_core

Programmable-logic core of the digitizer. It captures 16-bit ADC samples, or a generated test ramp, and packs them into 32-bit AXI-Stream packets of a software-set byte length for the AXI DMA (S2MM) to write into DDR. Software controls it through an AXI4-Lite register slave at 0x6000_0000, which sits on the PS general-purpose master port.

## Interface
- DATA_W, 32: AXI-Stream and AXI-Lite data width.
- ADDR_W, 4: AXI-Lite address bits decoded (byte address).
- Clock/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single system clock (PS FCLK); all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- adc_data  in  16  ADC sample, already synchronized to clk.
- adc_valid  in  1  one-cycle strobe qualifying adc_data.
- s_axi_aw*/w*/b*/ar*/r*: standard AXI4-Lite slave, ADDR_W address, 32-bit data, wstrb ignored.
- m_axis_tdata  out  32  packed samples, first sample in [15:0].
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tready  in  1  DMA ready.
- busy  out  1  capture in progress (drives the LED).

## Operation
- Register map (byte offsets):
  - 0x00 CTRL: bit0 START, bit1 TEST.
  - 0x04 STATUS (RO): bit0 BUSY, bit1 DONE, bit2 OVERFLOW.
  - 0x08 SIZE: packet length in bytes; bits [1:0] read back 0.
  - 0x0C SAMPLES (RO): beats sent in the current or last packet.
  - Unmapped reads return 0. All responses OKAY (2'b00).
- Starting a capture: a CTRL write with START=1 while idle latches TEST and SIZE, clears DONE, OVERFLOW and SAMPLES, then enters RUN.
  - CTRL writes while BUSY are ignored.
  - CTRL.START reads 1 while BUSY.
- FSM states:
  - IDLE -> RUN on a start write.
  - RUN -> IDLE after the handshake of the beat with tlast; DONE is then set and stays set (sticky).
  - SIZE=0 at start: go straight to IDLE with DONE=1; no beats are sent.
- Beat count N = SIZE/4. tlast is asserted on beat N.
- TEST=1: 16-bit counter c starts at 0. Each beat is {c+1, c}, then c advances by 2. A beat is offered every cycle. Example: beat0=0x0001_0000, beat1=0x0003_0002.
- TEST=0: the first adc_valid sample goes to [15:0] and the second to [31:16]; the completed word is offered as a beat.
  - A sample that arrives while a completed word is still unaccepted is dropped and sets OVERFLOW.
  - Capture continues after an overflow.

## Timing
- Reset values: all registers 0, tvalid=0, tlast=0, busy=0, bvalid=0, rvalid=0, awready=0, wready=0, arready=0.
- AXI-Lite write: awready and wready pulse for one cycle once both awvalid and wvalid are high. bvalid rises the next cycle and holds until bready.
- AXI-Lite read: arready pulses for one cycle. rvalid rises the next cycle and holds until rready.
- Start latency: the first beat's tvalid appears 1 cycle after the write handshake (TEST=1). With TEST=0 it appears 1 cycle after the second sample.
- AXI-Stream: tdata, tvalid and tlast are registered and stay stable while tvalid=1 and tready=0. A beat transfers when tvalid&&tready.
- BUSY falls and DONE rises in the cycle after the last handshake.
- resetn low mid-packet aborts immediately; the DMA is reset by the same reset.

## Structure
- Package digitizer_pkg holds the register offsets, CTRL/STATUS bit indices and the FSM state enum (IDLE, RUN).
- Sub-module digitizer_axil_regs implements the AXI-Lite slave and register file. The datapath and FSM stay in the core.

## Test plan
- Reset: hold resetn low for 20 cycles -> all outputs 0, STATUS reads 0x0, SIZE reads 0.
- Register access: write SIZE=0x0001_0000 -> write response 2'b00, readback 0x0001_0000. Write 0x0001_0003 -> readback 0x0001_0000.
- Test-mode packet: SIZE=65536, CTRL=0x3, tready=1 -> 16384 beats; beat k = {2k+1, 2k} mod 2^16; tlast only on beat 16383; then STATUS=0x2 and SAMPLES=16384.
- Backpressure: tready toggling randomly in test mode -> data sequence unchanged, no duplicated or skipped words, tdata stable while stalled.
- ADC mode: SIZE=8, CTRL=0x1, samples 0x1111, 0x2222, 0x3333, 0x4444 -> beats 0x2222_1111 then 0x4444_3333 with tlast; OVERFLOW=0.
- Edge cases:
  - SIZE=0 start -> DONE=1 with no beats.
  - A start write while BUSY is ignored.
  - A sample during a stall with a full word pending sets OVERFLOW.

Source files
------------

// File: rtl/digitizer_pkg.sv
// Shared constants for the digitizer core: register map, bit positions and FSM states.
package digitizer_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned CNT_W    = 30;

    localparam logic [ADDR_W-1:0] REG_CTRL    = 4'h0;
    localparam logic [ADDR_W-1:0] REG_STATUS  = 4'h4;
    localparam logic [ADDR_W-1:0] REG_SIZE    = 4'h8;
    localparam logic [ADDR_W-1:0] REG_SAMPLES = 4'hC;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_TEST   = 1;
    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;
    localparam int unsigned STAT_OVF    = 2;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Registers are word aligned; the two low address bits never select anything.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/digitizer_axil_regs.sv
// AXI4-Lite slave and register file; raises start_c on an accepted CTRL start write.
module digitizer_axil_regs
    import digitizer_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    input  logic                busy_i,
    input  logic                done_i,
    input  logic                overflow_i,
    input  logic [DATA_W-1:0]   samples_i,
    output logic [DATA_W-1:0]   size_o,
    output logic                start_c,
    output logic                start_test_c
);

    logic              aw_rdy_q, aw_rdy_d;
    logic              bvalid_q, bvalid_d;
    logic              ar_rdy_q, ar_rdy_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] size_q, size_d;
    logic              test_q, test_d;
    logic              wr_hs, rd_hs;
    logic              unused_bits;

    assign unused_bits = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign wr_hs        = aw_rdy_q && s_axi_awvalid && s_axi_wvalid;
    assign rd_hs        = ar_rdy_q && s_axi_arvalid;
    assign start_c      = wr_hs && (word_addr(s_axi_awaddr) == REG_CTRL)
                          && s_axi_wdata[CTRL_START] && !busy_i;
    assign start_test_c = s_axi_wdata[CTRL_TEST];

    // Handshake sequencing and register updates.
    always_comb begin
        aw_rdy_d = s_axi_awvalid && s_axi_wvalid && !aw_rdy_q && !bvalid_q;
        ar_rdy_d = s_axi_arvalid && !ar_rdy_q && !rvalid_q;
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        size_d   = size_q;
        test_d   = test_q;

        if (wr_hs) begin
            bvalid_d = 1'b1;
            if (word_addr(s_axi_awaddr) == REG_SIZE) begin
                size_d = {s_axi_wdata[DATA_W-1:2], 2'b00};
            end
            if (start_c) begin
                test_d = s_axi_wdata[CTRL_TEST];
            end
        end else if (s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (rd_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            case (word_addr(s_axi_araddr))
                REG_CTRL:    rdata_d = DATA_W'({test_q, busy_i});
                REG_STATUS:  rdata_d = DATA_W'({overflow_i, done_i, busy_i});
                REG_SIZE:    rdata_d = size_q;
                REG_SAMPLES: rdata_d = samples_i;
                default:     rdata_d = '0;
            endcase
        end else if (s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
            ar_rdy_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            size_q   <= '0;
            test_q   <= 1'b0;
        end else begin
            aw_rdy_q <= aw_rdy_d;
            bvalid_q <= bvalid_d;
            ar_rdy_q <= ar_rdy_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            size_q   <= size_d;
            test_q   <= test_d;
        end
    end

    assign s_axi_awready = aw_rdy_q;
    assign s_axi_wready  = aw_rdy_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = ar_rdy_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign size_o        = size_q;

endmodule

// File: rtl/digitizer_core.sv
// Digitizer capture core: packs ADC samples or a test ramp into AXI-Stream packets.
module digitizer_core
    import digitizer_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic                busy
);

    logic                state_q, state_d;
    logic                test_q, test_d;
    logic [CNT_W-1:0]    nbeats_q, nbeats_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   samples_q, samples_d;
    logic [SAMPLE_W-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] half_q, half_d;
    logic                have_half_q, have_half_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;

    logic [DATA_W-1:0]   size;
    logic                start_c, start_test_c;
    logic                accept, slot_free, more, is_last;
    logic                unused_size;

    digitizer_axil_regs u_regs (
        .clk           (clk),
        .resetn        (resetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .busy_i        (busy),
        .done_i        (done_q),
        .overflow_i    (ovf_q),
        .samples_i     (samples_q),
        .size_o        (size),
        .start_c       (start_c),
        .start_test_c  (start_test_c)
    );

    assign unused_size = ^size[1:0];
    assign accept      = tvalid_q && m_axis_tready;
    assign slot_free   = !tvalid_q || accept;
    assign more        = idx_q < nbeats_q;
    assign is_last     = idx_q == CNT_W'(nbeats_q - CNT_W'(1));

    // Next-state logic: start handling, beat generation and stream handshake.
    always_comb begin
        state_d     = state_q;
        test_d      = test_q;
        nbeats_d    = nbeats_q;
        idx_d       = idx_q;
        samples_d   = samples_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        have_half_d = have_half_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    test_d      = start_test_c;
                    nbeats_d    = size[DATA_W-1:2];
                    idx_d       = '0;
                    samples_d   = '0;
                    cnt_d       = '0;
                    have_half_d = 1'b0;
                    done_d      = 1'b0;
                    ovf_d       = 1'b0;
                    if (size[DATA_W-1:2] == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        // Ramp mode offers its first beat straight away.
                        if (start_test_c) begin
                            tdata_d  = 32'h0001_0000;
                            tvalid_d = 1'b1;
                            tlast_d  = size[DATA_W-1:2] == CNT_W'(1);
                            cnt_d    = 16'd2;
                            idx_d    = CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                if (accept) begin
                    samples_d = samples_q + DATA_W'(1);
                    tvalid_d  = 1'b0;
                    if (tlast_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        tlast_d = 1'b0;
                    end
                end
                if (test_q) begin
                    if (slot_free && more) begin
                        tdata_d  = {16'(cnt_q + 16'd1), cnt_q};
                        tvalid_d = 1'b1;
                        tlast_d  = is_last;
                        cnt_d    = 16'(cnt_q + 16'd2);
                        idx_d    = CNT_W'(idx_q + CNT_W'(1));
                    end
                end else if (adc_valid) begin
                    // A stalled word cannot be replaced, so the new sample is lost.
                    if (!slot_free) begin
                        ovf_d = 1'b1;
                    end else if (!have_half_q) begin
                        half_d      = adc_data;
                        have_half_d = 1'b1;
                    end else begin
                        have_half_d = 1'b0;
                        if (more) begin
                            tdata_d  = {adc_data, half_q};
                            tvalid_d = 1'b1;
                            tlast_d  = is_last;
                            idx_d    = CNT_W'(idx_q + CNT_W'(1));
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            test_q      <= 1'b0;
            nbeats_q    <= '0;
            idx_q       <= '0;
            samples_q   <= '0;
            cnt_q       <= '0;
            half_q      <= '0;
            have_half_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            test_q      <= test_d;
            nbeats_q    <= nbeats_d;
            idx_q       <= idx_d;
            samples_q   <= samples_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            have_half_q <= have_half_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = state_q == ST_RUN;

endmodule

// File: tb/tb_digitizer_core.sv
// Directed bench for digitizer_core: register access, ramp and ADC packets, overflow and start corner cases.
module tb_digitizer_core;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [3:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = 4'hF;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [3:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic        busy;

    int compared = 0;
    int mismatched = 0;
    int stall_err = 0;
    logic [32:0] beats[$];
    logic        stalled_q = 1'b0;
    logic [31:0] held_data_q = '0;
    logic        held_last_q = 1'b0;

    digitizer_core dut (
        .clk           (clk),
        .resetn        (resetn),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Stream monitor: log accepted beats, count any change of a stalled beat.
    always @(posedge clk) begin
        if (resetn) begin
            if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
            if (stalled_q && (!m_axis_tvalid || m_axis_tdata !== held_data_q || m_axis_tlast !== held_last_q))
                stall_err <= stall_err + 1;
            stalled_q   <= m_axis_tvalid && !m_axis_tready;
            held_data_q <= m_axis_tdata;
            held_last_q <= m_axis_tlast;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             output logic [1:0] resp, output logic tv_after);
        int n;
        logic got;
        resp = 2'b11;
        tv_after = 1'b0;
        @(negedge clk);
        s_axi_awaddr = addr; s_axi_wdata = data;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        got = 1'b0;
        for (n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = s_axi_awready && s_axi_wready;
        end
        if (!got) check("aw_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        tv_after = m_axis_tvalid;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        got = 1'b0;
        for (n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = s_axi_bvalid;
            resp = s_axi_bresp;
        end
        if (!got) check("b_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        logic got;
        data = 'x;
        @(negedge clk);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        got = 1'b0;
        for (n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = s_axi_arready;
        end
        if (!got) check("ar_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        got = 1'b0;
        for (n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = s_axi_rvalid;
            data = s_axi_rdata;
        end
        if (!got || s_axi_rresp !== 2'b00) check("r_handshake", {31'd0, got} | 32'(s_axi_rresp), 32'd1);
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        for (n = 0; n < max_cycles && busy; n++) @(negedge clk);
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send_sample(input logic [15:0] d);
        @(negedge clk);
        adc_data = d; adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        logic        tv;
        int          errs;
        logic [32:0] expb;

        // Reset
        repeat (20) @(negedge clk);
        check("rst_outputs", {23'd0, m_axis_tvalid, m_axis_tlast, busy, s_axi_bvalid, s_axi_rvalid,
                              s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
        resetn = 1'b1;
        axi_read(4'h4, rd); check("rst_status", rd, 32'h0);
        axi_read(4'h8, rd); check("rst_size", rd, 32'h0);

        // Register access
        axi_write(4'h8, 32'h0001_0000, resp, tv); check("size_bresp", 32'(resp), 32'd0);
        axi_read(4'h8, rd); check("size_rb", rd, 32'h0001_0000);
        axi_write(4'h8, 32'h0001_0003, resp, tv);
        axi_read(4'h8, rd); check("size_rb_lowbits", rd, 32'h0001_0000);

        // Ramp packet, 16384 beats, tready held high
        m_axis_tready = 1'b1;
        beats.delete();
        axi_write(4'h0, 32'h3, resp, tv);
        check("ramp_start_latency", 32'(tv), 32'd1);
        check("ramp_busy", 32'(busy), 32'd1);
        wait_idle(20000);
        check("ramp_count", 32'(beats.size()), 32'd16384);
        errs = 0;
        for (int k = 0; k < beats.size(); k++) begin
            expb = {k == 16383, 16'(2 * k + 1), 16'(2 * k)};
            if (beats[k] !== expb) errs++;
        end
        check("ramp_beats_bad", 32'(errs), 32'd0);
        if (beats.size() > 1) begin
            check("ramp_beat0", beats[0][31:0], 32'h0001_0000);
            check("ramp_beat1", beats[1][31:0], 32'h0003_0002);
        end
        axi_read(4'h4, rd); check("ramp_status", rd, 32'h2);
        axi_read(4'hC, rd); check("ramp_samples", rd, 32'd16384);
        axi_read(4'h0, rd); check("ramp_ctrl", rd, 32'h2);

        // Ramp with random backpressure, 16 beats
        m_axis_tready = 1'b0;
        axi_write(4'h8, 32'd64, resp, tv);
        beats.delete();
        axi_write(4'h0, 32'h3, resp, tv);
        for (int n = 0; n < 2000 && busy; n++) begin
            @(negedge clk);
            m_axis_tready = 1'($urandom_range(0, 1));
        end
        m_axis_tready = 1'b1;
        wait_idle(10);
        check("bp_count", 32'(beats.size()), 32'd16);
        errs = 0;
        for (int k = 0; k < beats.size(); k++) begin
            expb = {k == 15, 16'(2 * k + 1), 16'(2 * k)};
            if (beats[k] !== expb) errs++;
        end
        check("bp_beats_bad", 32'(errs), 32'd0);
        check("bp_stall_stable", 32'(stall_err), 32'd0);
        axi_read(4'hC, rd); check("bp_samples", rd, 32'd16);

        // ADC packet of two words
        axi_write(4'h8, 32'd8, resp, tv);
        beats.delete();
        axi_write(4'h0, 32'h1, resp, tv);
        check("adc_no_early_beat", 32'(m_axis_tvalid), 32'd0);
        send_sample(16'h1111);
        send_sample(16'h2222);
        check("adc_beat0_valid", {m_axis_tvalid, m_axis_tlast, m_axis_tdata[29:0]}, {2'b10, 30'h2222_1111});
        send_sample(16'h3333);
        send_sample(16'h4444);
        wait_idle(20);
        check("adc_count", 32'(beats.size()), 32'd2);
        if (beats.size() == 2) begin
            check("adc_beat0", beats[0][31:0], 32'h2222_1111);
            check("adc_beat1", beats[1][31:0], 32'h4444_3333);
            check("adc_tlast", {30'd0, beats[1][32], beats[0][32]}, 32'h2);
        end
        axi_read(4'h4, rd); check("adc_status", rd, 32'h2);

        // Overflow: sample arriving while a full word is stalled
        m_axis_tready = 1'b0;
        beats.delete();
        axi_write(4'h0, 32'h1, resp, tv);
        send_sample(16'hAAAA);
        send_sample(16'hBBBB);
        send_sample(16'hCCCC);
        axi_read(4'h4, rd); check("ovf_status_busy", rd, 32'h5);
        check("ovf_held_word", m_axis_tdata, 32'hBBBB_AAAA);
        @(negedge clk); m_axis_tready = 1'b1;
        send_sample(16'hDDDD);
        send_sample(16'hEEEE);
        wait_idle(20);
        check("ovf_count", 32'(beats.size()), 32'd2);
        if (beats.size() == 2) begin
            check("ovf_beat0", {1'b0, beats[0][32:2]}, {1'b0, 1'b0, 30'(32'hBBBB_AAAA >> 2)});
            check("ovf_beat1", beats[1][31:0], 32'hEEEE_DDDD);
        end
        axi_read(4'h4, rd); check("ovf_status_done", rd, 32'h6);

        // SIZE=0 start completes with no beats
        axi_write(4'h8, 32'd0, resp, tv);
        beats.delete();
        axi_write(4'h0, 32'h3, resp, tv);
        check("zero_no_tvalid", 32'(tv), 32'd0);
        repeat (5) @(negedge clk);
        axi_read(4'h4, rd); check("zero_status", rd, 32'h2);
        axi_read(4'hC, rd); check("zero_samples", rd, 32'd0);
        check("zero_beats", 32'(beats.size()), 32'd0);

        // Start write while busy is ignored
        m_axis_tready = 1'b0;
        axi_write(4'h8, 32'd16, resp, tv);
        beats.delete();
        axi_write(4'h0, 32'h3, resp, tv);
        axi_write(4'h0, 32'h1, resp, tv);
        check("busy_write_bresp", 32'(resp), 32'd0);
        axi_read(4'h0, rd); check("busy_ctrl", rd, 32'h3);
        axi_read(4'h4, rd); check("busy_status", rd, 32'h1);
        @(negedge clk); m_axis_tready = 1'b1;
        wait_idle(50);
        repeat (5) @(negedge clk);
        check("busy_restart_none", 32'(busy), 32'd0);
        check("busy_count", 32'(beats.size()), 32'd4);
        if (beats.size() == 4) check("busy_last_beat", {beats[3][32], beats[3][30:0]}, {1'b1, 31'h0007_0006});
        axi_read(4'hC, rd); check("busy_samples", rd, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
